// File: rtl/debounce_multi.sv
// debounce_multi: N-channel push-button debouncer with one shared sample tick.
//
// For each channel it produces a clean level, one-cycle press and release
// pulses, and (optionally) one-cycle auto-repeat pulses while the button is held.
//
// Ports:
//   clkDB       - system clock; all state changes on its rising edge
//   rst         - asynchronous, active-high reset
//   btn_in      - raw, asynchronous button inputs (1 = pressed)
//   btn_level   - debounced level per channel
//   btn_press   - one-cycle pulse on a debounced 0->1 transition
//   btn_release - one-cycle pulse on a debounced 1->0 transition
//   btn_rep     - one-cycle auto-repeat pulse while held (0 when REPEAT_EN = 0)
//   tick        - shared sample strobe, high for one cycle every TICK_DIV cycles
module debounce_multi #(
    parameter int N_CH         = 4,
    parameter int TICK_DIV     = 250000,
    parameter int STABLE_TICKS = 3,
    parameter int REPEAT_EN    = 0,
    parameter int REPEAT_DELAY = 200,
    parameter int REPEAT_RATE  = 40
) (
    input  logic            clkDB,
    input  logic            rst,
    input  logic [N_CH-1:0] btn_in,
    output logic [N_CH-1:0] btn_level,
    output logic [N_CH-1:0] btn_press,
    output logic [N_CH-1:0] btn_release,
    output logic [N_CH-1:0] btn_rep,
    output logic            tick
);

    localparam int            DW       = $clog2(TICK_DIV);
    localparam logic [DW-1:0] DIV_LAST = DW'(TICK_DIV - 1);
    localparam int            CW       = $clog2(STABLE_TICKS + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_TICKS - 1);

    logic [DW-1:0]   div_cnt;
    logic [N_CH-1:0] sync1;
    logic [N_CH-1:0] sync2;
    logic [CW-1:0]   stab_cnt [N_CH];
    logic [N_CH-1:0] flip;

    // Shared divider: counts 0..TICK_DIV-1, tick on the last count.
    always_ff @(posedge clkDB or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
        end else if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    assign tick = (div_cnt == DIV_LAST);

    // Two-flop synchroniser, clocked every cycle.
    always_ff @(posedge clkDB or posedge rst) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= btn_in;
            sync2 <= sync1;
        end
    end

    // A channel flips on the tick that completes STABLE_TICKS differing samples.
    always_comb begin
        flip = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            flip[i] = tick && (sync2[i] != btn_level[i]) && (stab_cnt[i] == CNT_LAST);
        end
    end

    always_ff @(posedge clkDB or posedge rst) begin
        if (rst) begin
            btn_level   <= '0;
            btn_press   <= '0;
            btn_release <= '0;
            for (int unsigned i = 0; i < N_CH; i++) begin
                stab_cnt[i] <= '0;
            end
        end else begin
            btn_press   <= '0;
            btn_release <= '0;
            if (tick) begin
                for (int unsigned i = 0; i < N_CH; i++) begin
                    if (sync2[i] == btn_level[i]) begin
                        stab_cnt[i] <= '0;
                    end else if (flip[i]) begin
                        btn_level[i]   <= ~btn_level[i];
                        btn_press[i]   <= ~btn_level[i];
                        btn_release[i] <= btn_level[i];
                        stab_cnt[i]    <= '0;
                    end else begin
                        stab_cnt[i] <= stab_cnt[i] + 1'b1;
                    end
                end
            end
        end
    end

    generate
        if (REPEAT_EN != 0) begin : g_rep
            localparam int HOLD_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
            localparam int HW       = $clog2(HOLD_MAX + 1);
            localparam logic [HW-1:0] HOLD_LAST = HW'(REPEAT_DELAY - 1);
            // A rate longer than the delay cannot be reached by reloading; restart from 0.
            localparam logic [HW-1:0] HOLD_RELOAD =
                HW'((REPEAT_DELAY > REPEAT_RATE) ? (REPEAT_DELAY - REPEAT_RATE) : 0);

            logic [HW-1:0] hold_cnt [N_CH];

            // Counter reaching REPEAT_DELAY is detected one step early so the
            // pulse is registered on the tick edge that would reach it.
            // A flip (press or release) has priority, so no repeat on those edges.
            always_ff @(posedge clkDB or posedge rst) begin
                if (rst) begin
                    btn_rep <= '0;
                    for (int unsigned i = 0; i < N_CH; i++) begin
                        hold_cnt[i] <= '0;
                    end
                end else begin
                    btn_rep <= '0;
                    for (int unsigned i = 0; i < N_CH; i++) begin
                        if (flip[i]) begin
                            hold_cnt[i] <= '0;
                        end else if (tick && btn_level[i]) begin
                            if (hold_cnt[i] == HOLD_LAST) begin
                                btn_rep[i]  <= 1'b1;
                                hold_cnt[i] <= HOLD_RELOAD;
                            end else begin
                                hold_cnt[i] <= hold_cnt[i] + 1'b1;
                            end
                        end
                    end
                end
            end
        end else begin : g_no_rep
            assign btn_rep = '0;
        end
    endgenerate

endmodule
